// File: rtl/lsu_mem_port.sv
// Load/store front end for a word-wide data memory. It accepts one access at a time,
// steers store bytes onto lanes, extends load data and reports misalignment, illegal codes and timeouts.
module lsu_mem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      load_i,
    input  logic [2:0]                LoadType_i,
    input  logic [1:0]                MemWrite_i,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic                      stall_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_ack_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    // Access size shares its encoding between MemWrite_i and LoadType_i[1:0].
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_reg;
    logic                    ready_reg;
    logic                    done_reg;
    logic                    err_reg;
    logic [1:0]              code_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    mem_req_reg;
    logic                    mem_we_reg;
    logic [NB-1:0]           mem_be_reg;
    logic [DATA_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        cnt_next;
    logic                    ld_reg;
    logic                    uns_reg;
    logic [1:0]              size_reg;
    logic [1:0]              lane_reg;

    logic                    op_store;
    logic                    op_load;
    logic                    illegal_load;
    logic                    misaligned;
    logic [1:0]              size_next;
    logic [NB-1:0]           be_next;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [NB-1:0]           lane_hit;
    logic [7:0]              rd_lane [NB];
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   ld_ext;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign rd_lane[gi]  = mem_rdata_i[8*gi +: 8];
            assign lane_hit[gi] = (addr_i[1:0] == 2'(gi));
        end
    endgenerate

    // Request decode: a store code wins over load_i.
    always_comb begin
        op_store     = (MemWrite_i != 2'b00);
        op_load      = !op_store && load_i;
        size_next    = op_store ? MemWrite_i : LoadType_i[1:0];
        illegal_load = op_load && ((LoadType_i[1:0] == 2'b00) || (LoadType_i == 3'b101));
        misaligned   = (op_store || op_load) &&
                       (((size_next == SZ_WORD) && (addr_i[1:0] != 2'b00)) ||
                        ((size_next == SZ_HALF) && addr_i[0]));
        be_next    = '0;
        wdata_next = '0;
        case (size_next)
            SZ_WORD: begin
                be_next    = '1;
                wdata_next = wdata_i;
            end
            SZ_HALF: begin
                be_next    = addr_i[1] ? NB'(4'b1100) : NB'(4'b0011);
                wdata_next = {(NB/2){wdata_i[15:0]}};
            end
            SZ_BYTE: begin
                be_next    = lane_hit;
                wdata_next = {NB{wdata_i[7:0]}};
            end
            default: ;
        endcase
        if (!op_store) begin
            wdata_next = '0;
        end
    end

    always_comb begin
        ld_byte = rd_lane[lane_reg];
        ld_half = lane_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};
        case (size_reg)
            SZ_BYTE: ld_ext = uns_reg ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                      : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = uns_reg ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                      : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    assign cnt_next = cnt_reg + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            code_reg      <= ERR_NONE;
            rdata_reg     <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cnt_reg       <= '0;
            ld_reg        <= 1'b0;
            uns_reg       <= 1'b0;
            size_reg      <= 2'b00;
            lane_reg      <= 2'b00;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            code_reg <= ERR_NONE;
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        ready_reg <= 1'b0;
                        ld_reg    <= op_load;
                        uns_reg   <= LoadType_i[2];
                        size_reg  <= size_next;
                        lane_reg  <= addr_i[1:0];
                        cnt_reg   <= '0;
                        if (!(op_store || op_load) || illegal_load || misaligned) begin
                            // No-ops and rejected requests finish without touching memory.
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= illegal_load || misaligned;
                            code_reg  <= illegal_load ? ERR_ILLEGAL :
                                         misaligned   ? ERR_MISALIGN : ERR_NONE;
                        end else begin
                            state_reg     <= ACCESS;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= op_store;
                            mem_be_reg    <= be_next;
                            mem_addr_reg  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            mem_wdata_reg <= wdata_next;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack_i || (cnt_next == CNT_MAX)) begin
                        state_reg     <= DONE;
                        done_reg      <= 1'b1;
                        mem_req_reg   <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_be_reg    <= '0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                        if (mem_ack_i) begin
                            if (ld_reg) begin
                                rdata_reg <= ld_ext;
                            end
                        end else begin
                            err_reg  <= 1'b1;
                            code_reg <= ERR_TIMEOUT;
                        end
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // The core is released in the DONE cycle, when the result is presented.
    assign stall_o     = (state_reg == ACCESS) || ((state_reg == IDLE) && req_valid_i);
    assign req_ready_o = ready_reg;
    assign rdata_o     = rdata_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;
    assign err_code_o  = code_reg;
    assign mem_req_o   = mem_req_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_be_o    = mem_be_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: each request pushes its expected completion,
// which the scenario tasks pop and compare when done_o appears.
module tb_lsu_mem_port;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        load_i = 1'b0;
    logic [2:0]  LoadType_i = 3'b000;
    logic [1:0]  MemWrite_i = 2'b00;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'hA5A5_A5A5;

    always #5 clk_i = ~clk_i;

    lsu_mem_port #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .load_i(load_i), .LoadType_i(LoadType_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [31:0] rdata;
        logic        we;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = 32'h0;

    function automatic exp_t model(input logic ld, input logic [2:0] lt, input logic [1:0] mw,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] mword, input logic [31:0] prev);
        exp_t        e;
        logic [7:0]  b;
        logic [15:0] h;
        e = '0;
        e.rdata = prev;
        e.maddr = {a[31:2], 2'b00};
        case (a[1:0])
            2'd0: b = mword[7:0];
            2'd1: b = mword[15:8];
            2'd2: b = mword[23:16];
            default: b = mword[31:24];
        endcase
        h = a[1] ? mword[31:16] : mword[15:0];
        if (mw != 2'b00) begin
            e.we = 1'b1;
            case (mw)
                2'b01: begin e.be = 4'hF; e.mwdata = wd; if (a[1:0] != 2'b00) e.code = 2'b01; end
                2'b10: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.mwdata = {wd[15:0], wd[15:0]}; if (a[0]) e.code = 2'b01; end
                default: begin e.be = 4'b0001 << a[1:0]; e.mwdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
            endcase
        end else if (ld) begin
            case (lt)
                3'b001: begin e.be = 4'hF; if (a[1:0] != 2'b00) e.code = 2'b01; else e.rdata = mword; end
                3'b010: begin e.be = a[1] ? 4'b1100 : 4'b0011; if (a[0]) e.code = 2'b01; else e.rdata = {{16{h[15]}}, h}; end
                3'b110: begin e.be = a[1] ? 4'b1100 : 4'b0011; if (a[0]) e.code = 2'b01; else e.rdata = {16'h0, h}; end
                3'b011: begin e.be = 4'b0001 << a[1:0]; e.rdata = {{24{b[7]}}, b}; end
                3'b111: begin e.be = 4'b0001 << a[1:0]; e.rdata = {24'h0, b}; end
                default: e.code = 2'b10;
            endcase
        end
        e.err = (e.code != 2'b00);
        return e;
    endfunction

    // Drives one request for the accept cycle; returns at cycle 1 (one edge later, +1).
    task automatic issue(input logic ld, input logic [2:0] lt, input logic [1:0] mw,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mword);
        exp_t e;
        e = model(ld, lt, mw, a, wd, mword, model_rdata);
        model_rdata = e.rdata;
        sb_q.push_back(e);
        req_valid_i = 1'b1; load_i = ld; LoadType_i = lt; MemWrite_i = mw; addr_i = a; wdata_i = wd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; load_i = 1'b0; LoadType_i = 3'b000; MemWrite_i = 2'b00; addr_i = 32'h0; wdata_i = 32'h0;
    endtask

    // Acks in cycle ack_delay+1 (never if negative); waits a bounded time for done_o.
    task automatic respond(input int ack_delay, input logic [31:0] mword, output int lat, output logic got);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (ack_delay >= 0 && lat == ack_delay + 1) begin
                mem_ack_i = 1'b1; mem_rdata_i = mword;
            end else begin
                mem_ack_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
            end
            @(posedge clk_i); #1;
            lat++;
        end
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'hA5A5_A5A5;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1 || mem_req_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 ||
            err_code_o !== 2'b00 || rdata_o !== 32'h0 || mem_be_o !== 4'h0 || mem_we_o !== 1'b0 ||
            mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b req=%b done=%b err=%b code=%b rdata=%h be=%b we=%b stall=%b, required ready=1 and all others 0",
                     req_ready_o, mem_req_o, done_o, err_o, err_code_o, rdata_o, mem_be_o, mem_we_o, stall_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1;
        #1;
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_request_stall: stall=%b, required 1", stall_o);
        end
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        $display("reset: checked");
    endtask

    task automatic test_loads();
        logic [2:0]  lt [6];
        logic [31:0] ad [6];
        logic [31:0] mw [6];
        int          dl [6];
        exp_t        e;
        int          lat;
        logic        got;
        lt = '{3'b011, 3'b110, 3'b010, 3'b111, 3'b001, 3'b010};
        ad = '{32'h103, 32'h202, 32'h202, 32'h101, 32'h200, 32'h100};
        mw = '{32'h80FF_1234, 32'hBEEF_0000, 32'hBEEF_0000, 32'h80FF_1234, 32'hDEAD_BEEF, 32'h1234_7FFF};
        dl = '{0, 1, 0, 2, 3, 0};
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, lt[i], 2'b00, ad[i], 32'h0, mw[i]);
            e = sb_q[$];
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_be_o !== e.be || mem_addr_o !== e.maddr) begin
                n_fail++;
                $display("FAIL load_issue[%0d]: req=%b we=%b be=%b addr=%h, required req=1 we=0 be=%b addr=%h",
                         i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, e.be, e.maddr);
            end
            respond(dl[i], mw[i], lat, got);
            e = sb_q.pop_front();
            n_checks++;
            if (!got || lat != dl[i] + 2) begin
                n_fail++;
                $display("FAIL load_latency[%0d]: done seen=%b at cycle %0d, required cycle %0d", i, got, lat, dl[i] + 2);
            end
            n_checks++;
            if (err_o !== e.err || err_code_o !== e.code || rdata_o !== e.rdata || stall_o !== 1'b0) begin
                n_fail++;
                $display("FAIL load_result[%0d]: err=%b code=%b rdata=%h stall=%b, required err=%b code=%b rdata=%h stall=0",
                         i, err_o, err_code_o, rdata_o, stall_o, e.err, e.code, e.rdata);
            end
            @(posedge clk_i); #1;
            n_checks++;
            if (done_o !== 1'b0 || req_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL load_done_pulse[%0d]: done=%b ready=%b, required done=0 ready=1", i, done_o, req_ready_o);
            end
            $display("load lt=%b addr=%h mem=%h -> rdata=%h latency=%0d", lt[i], ad[i], mw[i], rdata_o, lat);
        end
    endtask

    task automatic test_stores();
        logic [1:0]  mc [5];
        logic [31:0] ad [5];
        logic [31:0] wd [5];
        int          dl [5];
        exp_t        e;
        int          lat;
        logic        got;
        mc = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b10};
        ad = '{32'h101, 32'h104, 32'h102, 32'h103, 32'h200};
        wd = '{32'h1234_56AB, 32'hCAFE_F00D, 32'h1111_BEEF, 32'h0000_00C3, 32'h7777_5AA5};
        dl = '{0, 1, 0, 2, 0};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 3'b000, mc[i], ad[i], wd[i], 32'h0);
            e = sb_q[$];
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== e.be ||
                mem_addr_o !== e.maddr || mem_wdata_o !== e.mwdata) begin
                n_fail++;
                $display("FAIL store_issue[%0d]: req=%b we=%b be=%b addr=%h wdata=%h, required req=1 we=1 be=%b addr=%h wdata=%h",
                         i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, e.be, e.maddr, e.mwdata);
            end
            respond(dl[i], 32'hFFFF_FFFF, lat, got);
            e = sb_q.pop_front();
            n_checks++;
            if (!got || lat != dl[i] + 2 || err_o !== 1'b0 || rdata_o !== e.rdata) begin
                n_fail++;
                $display("FAIL store_done[%0d]: done seen=%b cycle=%0d err=%b rdata=%h, required cycle %0d err=0 rdata=%h",
                         i, got, lat, err_o, rdata_o, dl[i] + 2, e.rdata);
            end
            @(posedge clk_i); #1;
            $display("store code=%b addr=%h wdata=%h -> be=%b lanes=%h", mc[i], ad[i], wd[i], e.be, e.mwdata);
        end
    endtask

    task automatic test_store_priority();
        exp_t e;
        int   lat;
        logic got;
        issue(1'b1, 3'b011, 2'b01, 32'h10, 32'h5566_7788, 32'h0);
        n_checks++;
        if (mem_we_o !== 1'b1 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h5566_7788) begin
            n_fail++;
            $display("FAIL store_priority_issue: we=%b be=%b wdata=%h, required we=1 be=1111 wdata=55667788",
                     mem_we_o, mem_be_o, mem_wdata_o);
        end
        respond(0, 32'hFFFF_FFFF, lat, got);
        e = sb_q.pop_front();
        n_checks++;
        if (!got || err_o !== 1'b0 || rdata_o !== e.rdata) begin
            n_fail++;
            $display("FAIL store_priority_rdata: done seen=%b err=%b rdata=%h, required err=0 rdata=%h", got, err_o, rdata_o, e.rdata);
        end
        @(posedge clk_i); #1;
        $display("store with load_i=1 -> rdata held at %h", rdata_o);
    endtask

    task automatic test_errors();
        logic        ld [8];
        logic [2:0]  lt [8];
        logic [1:0]  mc [8];
        logic [31:0] ad [8];
        exp_t        e;
        ld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        lt = '{3'b000, 3'b001, 3'b100, 3'b000, 3'b101, 3'b000, 3'b010, 3'b000};
        mc = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        ad = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h001, 32'h103, 32'h203, 32'h104};
        for (int i = 0; i < 8; i++) begin
            issue(ld[i], lt[i], mc[i], ad[i], 32'hDEAD_0000, 32'h0);
            e = sb_q.pop_front();
            n_checks++;
            if (mem_req_o !== 1'b0 || done_o !== 1'b1) begin
                n_fail++;
                $display("FAIL early_done[%0d]: req=%b done=%b at cycle 1, required req=0 done=1", i, mem_req_o, done_o);
            end
            n_checks++;
            if (err_o !== e.err || err_code_o !== e.code || rdata_o !== e.rdata) begin
                n_fail++;
                $display("FAIL early_code[%0d]: err=%b code=%b rdata=%h, required err=%b code=%b rdata=%h",
                         i, err_o, err_code_o, rdata_o, e.err, e.code, e.rdata);
            end
            @(posedge clk_i); #1;
            $display("reject ld=%b lt=%b mw=%b addr=%h -> err=%b code=%b", ld[i], lt[i], mc[i], ad[i], e.err, e.code);
        end
    endtask

    task automatic test_timeout();
        exp_t        e;
        logic [31:0] prev;
        int          cnt;
        logic        got;
        prev = model_rdata;
        issue(1'b1, 3'b001, 2'b00, 32'h300, 32'h0, 32'h0);
        model_rdata = prev;
        e = sb_q.pop_front();
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (mem_req_o === 1'b1) cnt++;
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (!got || cnt != 16) begin
            n_fail++;
            $display("FAIL timeout_length: done seen=%b req high %0d cycles, required 16", got, cnt);
        end
        n_checks++;
        if (err_o !== 1'b1 || err_code_o !== 2'b11 || mem_req_o !== 1'b0 || rdata_o !== prev) begin
            n_fail++;
            $display("FAIL timeout_code: err=%b code=%b req=%b rdata=%h, required err=1 code=11 req=0 rdata=%h",
                     err_o, err_code_o, mem_req_o, rdata_o, prev);
        end
        @(posedge clk_i); #1;
        $display("timeout: req high %0d cycles, code=11 expected, load of %h discarded", cnt, e.maddr);
    endtask

    task automatic test_late_ack();
        exp_t e;
        issue(1'b0, 3'b000, 2'b01, 32'h308, 32'h0BAD_CAFE, 32'h0);
        e = sb_q[$];
        for (int c = 1; c <= 6; c++) begin
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== e.we || mem_be_o !== e.be || mem_addr_o !== e.maddr ||
                mem_wdata_o !== e.mwdata || stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL late_ack_hold[cycle %0d]: req=%b we=%b be=%b addr=%h wdata=%h stall=%b, required 1 %b %b %h %h stall=1",
                         c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, stall_o, e.we, e.be, e.maddr, e.mwdata);
            end
            if (c == 6) mem_ack_i = 1'b1;
            @(posedge clk_i); #1;
        end
        mem_ack_i = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (done_o !== 1'b1 || stall_o !== 1'b0 || err_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack_done: done=%b stall=%b err=%b req=%b, required done=1 stall=0 err=0 req=0",
                     done_o, stall_o, err_o, mem_req_o);
        end
        @(posedge clk_i); #1;
        $display("late ack: sw %h at %h completed at cycle 7", e.mwdata, e.maddr);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        logic got;
        issue(1'b1, 3'b111, 2'b00, 32'h102, 32'h0, 32'h00AB_0000);
        respond(0, 32'h00AB_0000, lat, got);
        e = sb_q.pop_front();
        n_checks++;
        if (!got || rdata_o !== e.rdata || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: done seen=%b rdata=%h ready=%b, required rdata=%h ready=0", got, rdata_o, req_ready_o, e.rdata);
        end
        // A request offered during DONE must not be taken.
        req_valid_i = 1'b1; load_i = 1'b1; LoadType_i = 3'b001; addr_i = 32'h104;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; load_i = 1'b0; LoadType_i = 3'b000; addr_i = 32'h0;
        n_checks++;
        if (mem_req_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_ignored: req=%b ready=%b, required req=0 ready=1", mem_req_o, req_ready_o);
        end
        issue(1'b1, 3'b001, 2'b00, 32'h104, 32'h0, 32'h0102_0304);
        respond(0, 32'h0102_0304, lat, got);
        e = sb_q.pop_front();
        n_checks++;
        if (!got || lat != 2 || rdata_o !== e.rdata) begin
            n_fail++;
            $display("FAIL b2b_second: done seen=%b cycle=%0d rdata=%h, required cycle 2 rdata=%h", got, lat, rdata_o, e.rdata);
        end
        @(posedge clk_i); #1;
        $display("back to back: lbu then lw -> rdata=%h", rdata_o);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic seen_done;
        int   lat;
        logic got;
        issue(1'b1, 3'b001, 2'b00, 32'h400, 32'h0, 32'h7777_7777);
        e = sb_q.pop_front();
        n_checks++;
        if (mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_access: req=%b before reset, required 1", mem_req_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        model_rdata = 32'h0;
        n_checks++;
        if (mem_req_o !== 1'b0 || req_ready_o !== 1'b1 || rdata_o !== 32'h0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_state: req=%b ready=%b rdata=%h stall=%b, required req=0 ready=1 rdata=0 stall=0",
                     mem_req_o, req_ready_o, rdata_o, stall_o);
        end
        seen_done = done_o;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0; mem_rdata_i = 32'hA5A5_A5A5;
            if (done_o === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0 || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done pulse seen=%b rdata=%h, required no pulse rdata=0", seen_done, rdata_o);
        end
        issue(1'b1, 3'b011, 2'b00, 32'h402, 32'h0, 32'h0042_0000);
        respond(1, 32'h0042_0000, lat, got);
        e = sb_q.pop_front();
        n_checks++;
        if (!got || lat != 3 || rdata_o !== e.rdata || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_recover: done seen=%b cycle=%0d rdata=%h err=%b, required cycle 3 rdata=%h err=0",
                     got, lat, rdata_o, err_o, e.rdata);
        end
        @(posedge clk_i); #1;
        $display("reset mid-access: aborted, next lb -> rdata=%h", rdata_o);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_store_priority();
        test_errors();
        test_timeout();
        test_late_ack();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
